rank_sched: RTL and testbench

- Sequential ranking controller for the game's score path.
- When the game FSM emits a score message, the block captures the score and inserts it into a sorted top-DEPTH leaderboard (lower score is better).
- Maintains best score (mpun) and previous score (apun) for the display mux.
- Serialises scan/shift over multiple cycles with a busy/done handshake, and offers a read port for the leaderboard display.

---
 rtl/rank_sched_pkg.sv | 23 ++
 rtl/rank_sched_table.sv | 61 ++++++
 rtl/rank_sched.sv | 143 ++++++++++++++
 tb/tb_rank_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rank_sched_pkg.sv
// rank_sched_pkg: shared definitions for the score ranking path.
//   - Message codes emitted by the game FSM (4-bit). Only MSG_PUN and
//     MSG_CLR are acted on by rank_sched; the others belong to the game.
//   - FSM state encoding for rank_sched.
package rank_sched_pkg;

  // Game FSM message codes
  localparam logic [3:0] MSG_NONE  = 4'b0000;
  localparam logic [3:0] MSG_START = 4'b0001;
  localparam logic [3:0] MSG_HIT   = 4'b0010;
  localparam logic [3:0] MSG_MISS  = 4'b0011;
  localparam logic [3:0] MSG_PUN   = 4'b1000;  // insert score on pun
  localparam logic [3:0] MSG_CLR   = 4'b1001;  // clear the leaderboard

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_CLEAR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rank_sched_table.sv
// rank_table: DEPTH-entry leaderboard storage with per-entry valid bits.
//   clk, rst           clock, asynchronous active-high reset
//   clr                invalidate every entry
//   shift_en/shift_idx entry[shift_idx] <= entry[shift_idx-1] (value+valid)
//   wr_en/wr_idx/wr_pun write a valid entry
//   scan_idx -> scan_pun/scan_ok   combinational read for the FSM scan
//   rd_idx   -> rd_pun/rd_ok       combinational read for the display
//   head_pun/head_ok               entry 0 (best score)
module rank_table #(
  parameter int PUN_BITS = 7,
  parameter int DEPTH    = 4,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic [IDX_W-1:0]    shift_idx,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [PUN_BITS-1:0] wr_pun,
  input  logic [IDX_W-1:0]    scan_idx,
  output logic [PUN_BITS-1:0] scan_pun,
  output logic                scan_ok,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [PUN_BITS-1:0] rd_pun,
  output logic                rd_ok,
  output logic [PUN_BITS-1:0] head_pun,
  output logic                head_ok
);

  logic [PUN_BITS-1:0] vals [DEPTH];
  logic [DEPTH-1:0]    vld;

  // NOTE: the entry array is small and its reset contents (all zero) are
  // observable on the read port, so it is reset like ordinary flops rather
  // than left uninitialised as a RAM would be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) vals[i] <= '0;
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (shift_en) begin
      // Caller guarantees shift_idx > 0 while shifting.
      vals[shift_idx] <= vals[shift_idx - 1'b1];
      vld[shift_idx]  <= vld[shift_idx - 1'b1];
    end else if (wr_en) begin
      vals[wr_idx] <= wr_pun;
      vld[wr_idx]  <= 1'b1;
    end
  end

  assign scan_pun = vals[scan_idx];
  assign scan_ok  = vld[scan_idx];
  assign rd_pun   = vals[rd_idx];
  assign rd_ok    = vld[rd_idx];
  assign head_pun = vals[0];
  assign head_ok  = vld[0];

endmodule

// File: rtl/rank_sched.sv
// rank_sched: captures scores from the game FSM and inserts them into a
// sorted top-DEPTH leaderboard (lower is better), one entry per cycle.
//   clk, rst          clock, asynchronous active-high reset
//   data, data_valid  message code and one-cycle qualifier
//   pun               score accompanying an insert message
//   busy, done        operation in progress / one-cycle completion pulse
//   mpun, apun        best stored score / last accepted score
//   count             number of valid entries
//   rd_idx -> rd_pun, rd_ok   display read port (combinational)
module rank_sched
  import rank_sched_pkg::*;
#(
  parameter int MENS_BITS = 4,
  parameter int PUN_BITS  = 7,
  parameter int DEPTH     = 4,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MENS_BITS-1:0] data,
  input  logic                 data_valid,
  input  logic [PUN_BITS-1:0]  pun,
  output logic                 busy,
  output logic                 done,
  output logic [PUN_BITS-1:0]  mpun,
  output logic [PUN_BITS-1:0]  apun,
  output logic [CNT_W-1:0]     count,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [PUN_BITS-1:0]  rd_pun,
  output logic                 rd_ok
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_t              state;
  logic [PUN_BITS-1:0] cand;
  logic [IDX_W-1:0]    idx, pos, sidx;

  logic [PUN_BITS-1:0] scan_pun, head_pun;
  logic                scan_ok, head_ok;
  logic                insert_here;

  // Strict compare: a tie lands after the existing equal entries.
  assign insert_here = !scan_ok || (cand < scan_pun);

  rank_table #(
    .PUN_BITS (PUN_BITS),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_CLEAR),
    .shift_en  ((state == ST_SHIFT) && (sidx != pos)),
    .shift_idx (sidx),
    .wr_en     ((state == ST_SHIFT) && (sidx == pos)),
    .wr_idx    (pos),
    .wr_pun    (cand),
    .scan_idx  (idx),
    .scan_pun  (scan_pun),
    .scan_ok   (scan_ok),
    .rd_idx    (rd_idx),
    .rd_pun    (rd_pun),
    .rd_ok     (rd_ok),
    .head_pun  (head_pun),
    .head_ok   (head_ok)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cand  <= '0;
      idx   <= '0;
      pos   <= '0;
      sidx  <= '0;
      count <= '0;
      mpun  <= '1;
      apun  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Messages arriving in any other state are silently dropped.
          if (data_valid && data == MENS_BITS'(MSG_PUN)) begin
            cand  <= pun;
            apun  <= pun;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end else if (data_valid && data == MENS_BITS'(MSG_CLR)) begin
            busy  <= 1'b1;
            state <= ST_CLEAR;
          end
        end
        ST_SCAN: begin
          if (insert_here) begin
            pos   <= idx;
            sidx  <= LAST_IDX;
            state <= ST_SHIFT;
          end else if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Always walks from the bottom entry up, so insert latency does
          // not depend on the insert position; the bottom entry falls off.
          if (sidx == pos) begin
            if (count != FULL_CNT) count <= count + 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            sidx <= sidx - 1'b1;
          end
        end
        ST_CLEAR: begin
          count <= '0;
          mpun  <= '1;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          mpun  <= head_ok ? head_pun : '1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rank_sched.sv
module tb_rank_sched;

  localparam int MENS_BITS = 4;
  localparam int PUN_BITS  = 7;
  localparam int DEPTH     = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 3;

  localparam logic [3:0] C_PUN = 4'b1000;
  localparam logic [3:0] C_CLR = 4'b1001;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [MENS_BITS-1:0] data;
  logic                 data_valid;
  logic [PUN_BITS-1:0]  pun;
  logic                 busy, done;
  logic [PUN_BITS-1:0]  mpun, apun, rd_pun;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_ok;

  int checks = 0;
  int errors = 0;

  rank_sched #(
    .MENS_BITS (MENS_BITS),
    .PUN_BITS  (PUN_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .pun        (pun),
    .busy       (busy),
    .done       (done),
    .mpun       (mpun),
    .apun       (apun),
    .count      (count),
    .rd_idx     (rd_idx),
    .rd_pun     (rd_pun),
    .rd_ok      (rd_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]             code;
    logic [6:0]             pun;
    int                     lat;   // edges from accept edge T to done sample
    int                     cnt;
    logic [6:0]             mp;
    logic [6:0]             ap;
    logic [3:0][6:0]        b;     // expected entries 0..3 (first cnt valid)
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] code, input logic [6:0] p, input int lat,
                              input int cnt, input logic [6:0] mp, input logic [6:0] ap,
                              input logic [6:0] b0, input logic [6:0] b1,
                              input logic [6:0] b2, input logic [6:0] b3);
    vec_t v;
    v.code = code; v.pun = p; v.lat = lat; v.cnt = cnt; v.mp = mp; v.ap = ap;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    return v;
  endfunction

  // One-cycle message pulse; returns at the negedge after accept edge T.
  task automatic send(input logic [3:0] code, input logic [6:0] p);
    @(negedge clk);
    data = code; pun = p; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; data = '0;
  endtask

  // Called at the negedge after edge T+start-1; returns latency k such that
  // done is first seen just before edge T+k, or -1 on timeout.
  task automatic wait_done(input int start, output int lat);
    lat = -1;
    for (int k = start; k < start + 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  // From the done cycle: check pulse width, then board and registers.
  task automatic check_after(input string tag, input int cnt, input logic [6:0] mp,
                             input logic [6:0] ap, input logic [3:0][6:0] b);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 1'b0);
    check({tag, " busy_low"}, busy, 1'b0);
    check({tag, " count"}, count, cnt);
    check({tag, " mpun"}, mpun, mp);
    check({tag, " apun"}, apun, ap);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      check($sformatf("%s rd_ok[%0d]", tag, i), rd_ok, (i < cnt));
      if (i < cnt) check($sformatf("%s rd_pun[%0d]", tag, i), rd_pun, b[i]);
    end
  endtask

  vec_t vecs [7];
  int   lat;
  logic [3:0][6:0] bb;

  initial begin
    vecs[0] = mk(C_PUN, 7'd50, 6, 1, 7'd50, 7'd50, 7'd50, 7'd0,  7'd0,  7'd0);
    vecs[1] = mk(C_PUN, 7'd40, 6, 2, 7'd40, 7'd40, 7'd40, 7'd50, 7'd0,  7'd0);
    vecs[2] = mk(C_PUN, 7'd60, 6, 3, 7'd40, 7'd60, 7'd40, 7'd50, 7'd60, 7'd0);
    vecs[3] = mk(C_PUN, 7'd40, 6, 4, 7'd40, 7'd40, 7'd40, 7'd40, 7'd50, 7'd60);
    vecs[4] = mk(C_PUN, 7'd30, 6, 4, 7'd30, 7'd30, 7'd30, 7'd40, 7'd40, 7'd50);
    vecs[5] = mk(C_PUN, 7'd50, 5, 4, 7'd30, 7'd50, 7'd30, 7'd40, 7'd40, 7'd50);
    vecs[6] = mk(C_CLR, 7'd0,  2, 0, 7'h7F, 7'd50, 7'd0,  7'd0,  7'd0,  7'd0);

    rst = 1'b1; data = '0; data_valid = 1'b0; pun = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst mpun", mpun, 7'h7F);
    check("rst apun", apun, 7'd0);
    check("rst count", count, 3'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      check($sformatf("rst rd_ok[%0d]", i), rd_ok, 1'b0);
    end

    // Table-driven inserts, rejected insert and clear
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].code, vecs[v].pun);
      check($sformatf("v%0d busy", v), busy, 1'b1);
      wait_done(1, lat);
      check($sformatf("v%0d latency", v), lat, vecs[v].lat);
      check_after($sformatf("v%0d", v), vecs[v].cnt, vecs[v].mp, vecs[v].ap, vecs[v].b);
    end

    // Pulse while busy is dropped; unknown code in IDLE is ignored.
    send(C_PUN, 7'd20);
    data = C_PUN; pun = 7'd10; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0; data = '0;
    wait_done(2, lat);
    check("busy_drop latency", lat, 6);
    bb = '0; bb[0] = 7'd20;
    check_after("busy_drop", 1, 7'd20, 7'd20, bb);
    send(4'b0011, 7'd5);
    check("ignored busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("ignored done", done, 1'b0);
    check_after("ignored", 1, 7'd20, 7'd20, bb);

    // Reset during SHIFT of the third insert
    send(C_PUN, 7'd30);
    wait_done(1, lat);
    check("ins30 latency", lat, 6);
    @(negedge clk);
    send(C_PUN, 7'd10);
    @(negedge clk);  // after edge T+1: 10 < 20 so the FSM is shifting
    check("mid busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst count", count, 3'd0);
    check("midrst mpun", mpun, 7'h7F);
    check("midrst apun", apun, 7'd0);
    rd_idx = '0;
    #1;
    check("midrst rd_ok0", rd_ok, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Refill then clear
    send(C_PUN, 7'd25);
    wait_done(1, lat);
    @(negedge clk);
    send(C_PUN, 7'd15);
    wait_done(1, lat);
    bb = '0; bb[0] = 7'd15; bb[1] = 7'd25;
    check_after("refill", 2, 7'd15, 7'd15, bb);
    send(C_CLR, 7'd0);
    wait_done(1, lat);
    check("clr latency", lat, 2);
    bb = '0;
    check_after("clr", 0, 7'h7F, 7'd15, bb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
